// File: rtl/bloco_controle.sv
// Multicycle sequencer for the register-bank / ULA / flag-register datapath.
// Accepts instructions over valid/ready and steps them through a fixed state sequence.
module bloco_controle #(
    parameter int bits_palavra = 16,
    parameter int end_registros = 4,
    parameter logic [4:0] OP_NEUTRA = 5'b00000,
    parameter int bits_contador = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [bits_palavra-1:0]  instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     hold,
    output logic                     Hab_Escrita,
    output logic                     en,
    output logic [end_registros-1:0] Sel_SA,
    output logic [end_registros-1:0] Sel_SB,
    output logic [4:0]               controleOperacao,
    output logic                     reset_Ban_Registros,
    output logic                     reset_Flags,
    output logic                     busy,
    output logic                     ilegal,
    output logic [bits_contador-1:0] num_instr
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] CLEAR  = 3'd4;

    localparam logic [2:0] C_NOP = 3'b000;
    localparam logic [2:0] C_ALU = 3'b001;
    localparam logic [2:0] C_CMP = 3'b010;
    localparam logic [2:0] C_CLR = 3'b011;
    localparam logic [2:0] C_CLF = 3'b100;

    logic [2:0]                state, nxt;
    logic [bits_palavra-1:0]   ir, n_ir;
    logic                      n_ready, n_we, n_en, n_rb, n_rf, n_busy, n_ileg;
    logic [end_registros-1:0]  n_sa, n_sb;
    logic [4:0]                n_op;
    logic [bits_contador-1:0]  n_cnt;
    logic [2:0]                cls;

    assign cls = ir[10:8];

    always_comb begin
        nxt     = state;
        n_ir    = ir;
        n_ready = instr_ready;
        n_we    = Hab_Escrita;
        n_en    = en;
        n_sa    = Sel_SA;
        n_sb    = Sel_SB;
        n_op    = controleOperacao;
        n_rb    = reset_Ban_Registros;
        n_rf    = reset_Flags;
        n_busy  = busy;
        n_ileg  = ilegal;
        n_cnt   = num_instr;
        if (hold) begin
            // Everything freezes; only the idle handshake is withdrawn.
            if (state == IDLE)
                n_ready = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    n_ready = 1'b1;
                    n_ileg  = 1'b0;
                    n_op    = OP_NEUTRA;
                    n_we    = 1'b0;
                    n_en    = 1'b0;
                    n_rb    = 1'b0;
                    n_rf    = 1'b0;
                    if (instr_valid && instr_ready) begin
                        n_ir    = instr;
                        nxt     = DECODE;
                        n_ready = 1'b0;
                        n_busy  = 1'b1;
                        n_sa    = instr[7:4];
                        n_sb    = instr[3:0];
                        if (instr[10:8] == C_ALU || instr[10:8] == C_CMP)
                            n_op = instr[15:11];
                    end
                end
                DECODE: begin
                    unique case (1'b1)
                        (cls == C_ALU), (cls == C_CMP): nxt = EXEC;
                        (cls == C_CLR): begin
                            nxt  = CLEAR;
                            n_rb = 1'b1;
                        end
                        (cls == C_CLF): begin
                            nxt  = CLEAR;
                            n_rf = 1'b1;
                        end
                        (cls == C_NOP): begin
                            nxt   = IDLE;
                            n_cnt = num_instr + 1'b1;
                        end
                        default: begin
                            nxt    = IDLE;
                            n_ileg = 1'b1;
                        end
                    endcase
                end
                EXEC: begin
                    if (cls == C_ALU) begin
                        nxt  = WRITE;
                        n_we = 1'b1;
                        n_en = 1'b1;
                    end else begin
                        nxt   = IDLE;
                        n_cnt = num_instr + 1'b1;
                    end
                end
                WRITE, CLEAR: begin
                    nxt   = IDLE;
                    n_cnt = num_instr + 1'b1;
                end
                default: nxt = IDLE;
            endcase
            if (nxt == IDLE && state != IDLE) begin
                n_ready = 1'b1;
                n_busy  = 1'b0;
                n_op    = OP_NEUTRA;
                n_we    = 1'b0;
                n_en    = 1'b0;
                n_rb    = 1'b0;
                n_rf    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            ir                  <= '0;
            instr_ready         <= 1'b0;
            Hab_Escrita         <= 1'b0;
            en                  <= 1'b0;
            Sel_SA              <= '0;
            Sel_SB              <= '0;
            controleOperacao    <= OP_NEUTRA;
            reset_Ban_Registros <= 1'b0;
            reset_Flags         <= 1'b0;
            busy                <= 1'b0;
            ilegal              <= 1'b0;
            num_instr           <= '0;
        end else begin
            state               <= nxt;
            ir                  <= n_ir;
            instr_ready         <= n_ready;
            Hab_Escrita         <= n_we;
            en                  <= n_en;
            Sel_SA              <= n_sa;
            Sel_SB              <= n_sb;
            controleOperacao    <= n_op;
            reset_Ban_Registros <= n_rb;
            reset_Flags         <= n_rf;
            busy                <= n_busy;
            ilegal              <= n_ileg;
            num_instr           <= n_cnt;
        end
    end

endmodule

// File: doc/bloco_controle.md
Name: bloco_controle

Overview:
- Multicycle sequencer for the register-bank / ULA / flag-register datapath.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes each word.
- Drives the datapath's write enable, register selects, ULA operation code and clear strobes in a fixed state sequence.
- Reports busy, illegal-instruction and retired-instruction count to the surrounding top level.

Parameters:
- bits_palavra, 16, instruction word width (fixed layout below assumes 16)
- end_registros, 4, register address width
- OP_NEUTRA, 5'b00000, ULA code driven whenever no ALU/CMP is in flight
- bits_contador, 16, width of retired-instruction counter

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low; clears all state
- instr  in  bits_palavra  instruction word
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  controller accepts instr this cycle
- hold  in  1  freezes FSM and all registered outputs while high
- Hab_Escrita  out  1  register-bank write enable
- en  out  1  register-bank clock enable
- Sel_SA  out  end_registros  destination / operand A address
- Sel_SB  out  end_registros  operand B address
- controleOperacao  out  5  ULA operation code
- reset_Ban_Registros  out  1  active-high register-bank clear strobe
- reset_Flags  out  1  active-high flag-register clear strobe
- busy  out  1  high in any state other than IDLE
- ilegal  out  1  one-cycle pulse on an undefined class
- num_instr  out  bits_contador  retired-instruction count

Behaviour:
- Instruction layout: [15:11] opcode, [10:8] class, [7:4] SA, [3:0] SB.
- Classes: 000 NOP; 001 ALU (compute, write into SA); 010 CMP (compute, flags only); 011 CLRREG; 100 CLRFLG; 101-111 illegal.
- Reset values: instr_ready=0 during reset, then 1 in IDLE. Hab_Escrita=0, en=0, Sel_SA=0, Sel_SB=0, controleOperacao=OP_NEUTRA, reset_Ban_Registros=0, reset_Flags=0, busy=0, ilegal=0, num_instr=0. Internal IR=0.
- All outputs are registered; no combinational path from instr to any output.
- FSM states: IDLE, DECODE, EXEC, WRITE, CLEAR.
- IDLE
  - instr_ready=1.
  - On instr_valid & instr_ready & !hold: capture instr into IR, go to DECODE.
  - instr_valid while busy is ignored; the source holds it until accepted.
- DECODE (1 cycle)
  - Drive Sel_SA=IR[7:4] and Sel_SB=IR[3:0].
  - ALU/CMP: controleOperacao=IR[15:11], go to EXEC.
  - CLRREG/CLRFLG: go to CLEAR.
  - NOP: num_instr+1, go to IDLE.
  - Illegal: ilegal=1 for the cycle entering IDLE; num_instr is not incremented.
- EXEC (1 cycle)
  - Selects and opcode held stable so operands and flags settle.
  - ALU: go to WRITE.
  - CMP: num_instr+1, go to IDLE.
- WRITE (1 cycle)
  - Hab_Escrita=1, en=1; the ULA result is written to Sel_SA.
  - num_instr+1, then IDLE.
  - Hab_Escrita and en are high in no other state.
- CLEAR (1 cycle)
  - CLRREG: reset_Ban_Registros=1. CLRFLG: reset_Flags=1.
  - Only one strobe per instruction; num_instr+1, then IDLE.
- Latency (hold low): ALU = 4 cycles accept-to-accept; CMP and CLR* = 3; NOP and illegal = 2.
- Returning to IDLE restores controleOperacao=OP_NEUTRA and deasserts all strobes.
- hold
  - Freezes state, IR, counter and every output at current value.
  - A WRITE or CLEAR cycle frozen by hold keeps its strobe high.
  - In IDLE, hold forces instr_ready=0 from the next cycle.
- num_instr wraps from all-ones to 0 silently.
- Reset mid-operation: immediate return to IDLE with reset values; no partial write or clear strobe is emitted after reset deasserts.

Test Plan:
- After reset, send ALU instr 16'b00001_001_0000_0011 (op 1, SA=0, SB=3) -> DECODE shows Sel_SA=0/Sel_SB=3; controleOperacao=1 in DECODE/EXEC/WRITE; Hab_Escrita=en=1 exactly in cycle 4; num_instr=1.
- CMP op 2, SA=5, SB=6 -> no Hab_Escrita at any point; busy high for 2 cycles after accept; num_instr increments.
- CLRREG then CLRFLG back-to-back with instr_valid held high -> one-cycle reset_Ban_Registros, then one-cycle reset_Flags, never overlapping; instr_ready low while busy.
- Class 111 -> single ilegal pulse, counter unchanged, next instr accepted 2 cycles after first accept.
- Assert hold during WRITE for 3 cycles -> Hab_Escrita high for 4 cycles total, state and counter frozen; release -> IDLE.
- Drive reset low during EXEC of an ALU instr -> all outputs at reset values asynchronously, no write after release; preload counter at 16'hFFFF and retire a NOP -> num_instr=0.
